// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: memory sizing and frame states.
package inst_loader_pkg;

    localparam int unsigned INST_ADDR_SIZE = 6;
    localparam int unsigned DEF_MAX_WORDS  = 1 << INST_ADDR_SIZE;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_CNT_HI = 3'd0;
    localparam logic [STATE_W-1:0] ST_CNT_LO = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CSUM   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd5;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Byte-to-word assembly (MSB first), byte lane tracking and running XOR of frame bytes.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [7:0]  csum,
    output logic        word_done_c,
    output logic [31:0] word_c
);

    // Only the first three bytes of a word need holding; the fourth arrives with word_done_c.
    logic [23:0] shreg;
    logic [1:0]  lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum  <= 8'd0;
            shreg <= 24'd0;
            lane  <= 2'd0;
        end else begin
            if (byte_en) begin
                csum <= csum ^ data;
            end
            if (shift_en) begin
                shreg <= {shreg[15:0], data};
                lane  <= lane + 2'd1;
            end
        end
    end

    assign word_done_c = shift_en && (lane == 2'd3);
    assign word_c      = {shreg, data};

endmodule

// File: rtl/inst_loader.sv
// Frame-receiving instruction-memory loader: writes assembled words, then raises lock on a good checksum.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = INST_ADDR_SIZE,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              lock,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [7:0]         cnt_hi;
    logic [CNT_W-1:0]   count;
    logic [15:0]        frame_cnt_c;
    logic               accept_c;
    logic               cnt_hi_ld;
    logic               count_ld;
    logic               we_nxt;
    logic [7:0]         csum;
    logic               word_done_c;
    logic [31:0]        word_c;

    assign accept_c    = rx_valid && rx_ready;
    assign frame_cnt_c = {cnt_hi, rx_data};

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_en     (accept_c && (state != ST_CSUM)),
        .shift_en    (accept_c && (state == ST_DATA)),
        .data        (rx_data),
        .csum        (csum),
        .word_done_c (word_done_c),
        .word_c      (word_c)
    );

    // Next-state and write-strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_hi_ld = 1'b0;
        count_ld  = 1'b0;
        we_nxt    = 1'b0;
        case (state)
            ST_CNT_HI: begin
                if (accept_c) begin
                    cnt_hi_ld = 1'b1;
                    state_nxt = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept_c) begin
                    if (frame_cnt_c > 16'(MAX_WORDS)) begin
                        state_nxt = ST_ERROR;
                    end else if (frame_cnt_c == 16'd0) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        count_ld  = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done_c) begin
                    we_nxt = 1'b1;
                    if ((words_loaded + CNT_W'(1)) == count) begin
                        state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    state_nxt = (rx_data == csum) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE:  state_nxt = ST_DONE;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_CNT_HI;
            rx_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            lock         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            cnt_hi       <= 8'd0;
            count        <= '0;
        end else begin
            state    <= state_nxt;
            rx_ready <= (state_nxt != ST_DONE) && (state_nxt != ST_ERROR);
            imem_we  <= we_nxt;
            lock     <= (state_nxt == ST_DONE);
            err      <= (state_nxt == ST_ERROR);
            if (cnt_hi_ld) begin
                cnt_hi <= rx_data;
            end
            // Count already range-checked against MAX_WORDS, so it fits CNT_W bits.
            if (count_ld) begin
                count <= CNT_W'(frame_cnt_c);
            end
            if (we_nxt) begin
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= word_c;
                words_loaded <= words_loaded + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        lock;
    logic        err;
    logic [6:0]  words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  frame[$];
    int          both_high  = 0;
    int          we_in_lock = 0;

    inst_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .lock         (lock),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (lock && err) both_high++;
        if (lock && imem_we) we_in_lock++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was transferred.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 16 && !ok; i++) begin
            ok = rx_ready;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                for (int k = 0; k < g; k++) @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_frame_a(input logic [7:0] csum_byte);
        frame = '{8'h00, 8'h02, 8'h28, 8'h10, 8'h00, 8'h05,
                  8'h08, 8'h32, 8'h10, 8'h00, csum_byte};
    endtask

    task automatic check_two_writes(input string pfx);
        check({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({pfx, "_a0"}, 32'(wr_addr[0]), 32'd0);
            check({pfx, "_d0"}, wr_data[0], 32'h2810_0005);
            check({pfx, "_a1"}, 32'(wr_addr[1]), 32'd1);
            check({pfx, "_d1"}, wr_data[1], 32'h0832_1000);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check("rst_ready", 32'(rx_ready), 32'd1);
        check("rst_we",    32'(imem_we), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_lock",  32'(lock), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word load with write-latency probe on the first word.
        load_frame_a(8'h15);
        for (int i = 0; i < 6; i++) send_byte(frame[i]);
        check("t1_we_lat",   32'(imem_we), 32'd1);
        check("t1_addr_lat", 32'(imem_addr), 32'd0);
        check("t1_data_lat", imem_wdata, 32'h2810_0005);
        for (int i = 6; i < 10; i++) send_byte(frame[i]);
        check("t1_lock_pre", 32'(lock), 32'd0);
        send_byte(frame[10]);
        check("t1_lock", 32'(lock), 32'd1);
        check("t1_err",  32'(err), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_ready", 32'(rx_ready), 32'd0);
        check_two_writes("t1");

        // Bad checksum.
        do_reset();
        load_frame_a(8'h14);
        send_frame(0);
        @(negedge clk);
        check("t2_err",   32'(err), 32'd1);
        check("t2_lock",  32'(lock), 32'd0);
        check("t2_ready", 32'(rx_ready), 32'd0);
        check_two_writes("t2");

        // Empty frame.
        do_reset();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("t3_lock",  32'(lock), 32'd1);
        check("t3_err",   32'(err), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd0);
        check("t3_nwr",   32'(wr_addr.size()), 32'd0);

        // Oversize count.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h41);
        check("t4_err",   32'(err), 32'd1);
        check("t4_lock",  32'(lock), 32'd0);
        check("t4_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_nwr",   32'(wr_addr.size()), 32'd0);

        // Maximum legal count: data byte j = j, so XOR of data is 0 and CSUM = 0x40.
        do_reset();
        frame = '{8'h00, 8'h40};
        for (int j = 0; j < 256; j++) frame.push_back(8'(j));
        frame.push_back(8'h40);
        send_frame(0);
        check("t5_lock",  32'(lock), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd64);
        check("t5_nwr",   32'(wr_addr.size()), 32'd64);
        if (wr_addr.size() == 64) begin
            for (int k = 0; k < 64; k += 21) begin
                check("t5_addr", 32'(wr_addr[k]), 32'(k));
                check("t5_data", wr_data[k],
                      {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
            end
            check("t5_last", wr_data[63], 32'hFCFD_FEFF);
        end

        // Random idle gaps between bytes.
        do_reset();
        load_frame_a(8'h15);
        send_frame(3);
        check("t6_lock",  32'(lock), 32'd1);
        check("t6_err",   32'(err), 32'd0);
        check("t6_words", 32'(words_loaded), 32'd2);
        check_two_writes("t6");

        // Async reset mid-frame, then full resend.
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(frame[i]);
        check("t7_pre_words", 32'(words_loaded), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_ready", 32'(rx_ready), 32'd1);
        check("t7_rst_words", 32'(words_loaded), 32'd0);
        check("t7_rst_addr",  32'(imem_addr), 32'd0);
        check("t7_rst_wdata", imem_wdata, 32'd0);
        check("t7_rst_lock",  32'(lock), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        send_frame(0);
        check("t7_lock", 32'(lock), 32'd1);
        check("t7_err",  32'(err), 32'd0);
        check_two_writes("t7");

        check("inv_lock_err", 32'(both_high), 32'd0);
        check("inv_we_lock",  32'(we_in_lock), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
